apb_completer_regfile: RTL and testbench
========================================

Name: apb_completer_regfile

Overview:
- APB4/APB5 completer: the responder end of the APB link driven by the team's requester in top.
- Holds NUM_REGS 32-bit registers with byte-strobe writes and programmable wait states.
- Flags bad address, misalignment or illegal protection attributes on PSLVERR.
- Sits on the peripheral side of the APB requester and serves as the default register target for bench and SoC integration.

Parameters:
- ADDR_W, 32, PADDR width.
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 0, PREADY-low cycles in the access phase; 0..15.

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSELx  in  1  completer select.
- PENABLE  in  1  access phase indicator.
- PADDR  in  ADDR_W  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes; PSTRB[n] covers PWDATA[8n+7:8n].
- PPROT  in  3  protection: [0] privileged, [1] non-secure, [2] instruction.
- PNSE  in  1  APB5 extension of PPROT[1].
- PRDATA  out  32  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous): all registers 0, state IDLE, wait counter 0, PREADY=0, PSLVERR=0, PRDATA=0.
- FSM states IDLE and ACCESS.
- IDLE: PSELx=1 and PENABLE=0 (setup phase) causes the block to:
  - latch PADDR, PWRITE, PWDATA, PSTRB, PPROT and PNSE;
  - compute err;
  - load cnt = WAIT_STATES;
  - move to ACCESS.
  - Any other input combination keeps the block in IDLE.
- ACCESS, cnt != 0: PREADY=0; cnt decrements each cycle.
- ACCESS, cnt == 0: PREADY=1, combinational from state/count. PSLVERR=err, PRDATA = selected register on an error-free read, else 0.
- Completion edge, defined as PSELx & PENABLE & PREADY:
  - error-free write: update each byte whose strobe bit is 1; bytes with strobe 0 keep their value;
  - always: state returns to IDLE.
- Latency: WAIT_STATES=0 gives a 2-cycle transfer (setup, access). Each wait state adds 1 cycle.
- Back-to-back: the cycle after completion is IDLE and accepts a new setup in that cycle.
- err=1 when any of the following holds:
  - PADDR[1:0] != 0;
  - word index PADDR>>2 >= NUM_REGS;
  - PNSE=1 with PPROT[1]=0 (reserved encoding).
- Erroring writes modify nothing. Erroring reads return PRDATA=0.
- Reads ignore PSTRB. A write with PSTRB=0 completes with no data change and PSLVERR=0.
- PSELx deasserted while in ACCESS (protocol violation): return to IDLE next edge, no write, PREADY=0.
- PENABLE=0 while in ACCESS: cnt still counts down. Completion waits for PENABLE=1.
- Reset asserted mid-transfer: pending write dropped, registers cleared, outputs to reset values immediately.
- Input changes during ACCESS are ignored; the latched setup values are used.

Optional Feature:
- Macro: APB_SECURE_REGION_EN.
- Defined:
  - register indices >= NUM_REGS/2 are secure-only;
  - an access to them with PPROT[1]=1 (non-secure or realm) sets err: PSLVERR=1, no write, PRDATA=0;
  - secure accesses (PPROT[1]=0) behave normally.
- Undefined: PPROT and PNSE affect only the reserved-encoding check. All in-range registers are accessible from any security state.

Test Plan:
- Strobe writes, WAIT_STATES=0, after reset:
  - write 0x0 = DEADBEEF, PSTRB 1111; write 0x4 = ABCDABCD, PSTRB 0101; write 0x8 = 12345678, PSTRB 1010;
  - then read each back -> DEADBEEF, 00CD00CD, 12005600;
  - every transfer has PREADY high in the 2nd cycle and PSLVERR=0.
- WAIT_STATES=3: write 0xC = A5A5A5A5 then read 0xC -> PREADY low for exactly 3 access cycles, then high; read returns A5A5A5A5.
- Errors, NUM_REGS=16:
  - write 0x40 = FFFFFFFF -> PSLVERR=1, no register changes; read 0x40 -> PRDATA=0, PSLVERR=1;
  - read 0x2 (misaligned) -> PSLVERR=1;
  - read 0x0 with PPROT=000, PNSE=1 -> PSLVERR=1.
- Back-to-back: write 0x4 = 11111111 (PSTRB 1111) immediately followed by read 0x4 with no idle cycle -> second setup accepted in the cycle after completion; read returns 11111111.
- Disruptions:
  - PRESETn pulsed low during the access phase of write 0x0 = 0BADF00D -> outputs 0 immediately; read 0x0 after reset returns 00000000;
  - PSELx dropped mid-ACCESS -> no write, FSM in IDLE.
- With APB_SECURE_REGION_EN, NUM_REGS=16:
  - write 0x20 = CAFEF00D with PPROT=010 -> PSLVERR=1, register unchanged;
  - same write with PPROT=000 -> PSLVERR=0; read with PPROT=000 returns CAFEF00D.

Source files
------------

// File: rtl/apb_completer_regfile.sv
// APB4/APB5 completer register file: NUM_REGS x 32-bit registers with byte
// strobes, programmable wait states and PSLVERR on bad address, misalignment
// or reserved protection encodings.
// Optional build macro APB_SECURE_REGION_EN: upper half of the register map
// becomes secure-only (non-secure accesses error out).
module apb_completer_regfile #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PSTRB,
    input  logic [2:0]        PPROT,
    input  logic              PNSE,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Setup-phase values captured for the whole access phase
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  strb_q;
    logic               err_q;

    logic [DATA_W-1:0]  regs_q [NUM_REGS];

    logic               setup_c;
    logic               complete_c;
    logic               wr_en_c;
    logic               ready_c;
    logic [WORD_W-1:0]  word_c;
    logic               misalign_c;
    logic               range_err_c;
    logic               prot_err_c;
    logic               sec_err_c;
    logic               err_c;
    logic               unused_prot_c;

    // Privileged and instruction attributes do not gate any access
    assign unused_prot_c = ^{PPROT[2], PPROT[0]};

    // Error classification of the address/protection presented in setup
    always_comb begin
        word_c      = PADDR[ADDR_W-1:2];
        misalign_c  = |PADDR[1:0];
        range_err_c = (word_c >= WORD_W'(NUM_REGS));
        prot_err_c  = PNSE & ~PPROT[1];
`ifdef APB_SECURE_REGION_EN
        // Top index bit set means the upper (secure-only) half of the map
        sec_err_c   = PADDR[IDX_W+1] & PPROT[1];
`else
        sec_err_c   = 1'b0;
`endif
        err_c       = misalign_c | range_err_c | prot_err_c | sec_err_c;
    end

    assign setup_c    = (state_q == IDLE) & PSELx & ~PENABLE;
    assign complete_c = (state_q == ACCESS) & PSELx & PENABLE & ready_c;
    assign wr_en_c    = complete_c & wr_q & ~err_q;

    // FSM state and wait counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait countdown and completer response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_c = 1'b0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        case (state_q)
            IDLE: begin
                if (setup_c) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                ready_c = (cnt_q == '0);
                PREADY  = ready_c;
                PSLVERR = ready_c & err_q;
                if (ready_c && !wr_q && !err_q) begin
                    PRDATA = regs_q[idx_q];
                end
                if (!PSELx) begin
                    // Requester abandoned the transfer: drop it silently
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    // Countdown runs whether or not PENABLE is high
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (PENABLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture transfer attributes in the setup phase
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (setup_c) begin
            idx_q   <= PADDR[IDX_W+1:2];
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= err_c;
        end
    end

    // Register array: byte-strobed update on an error-free write completion
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb_q[b]) begin
                    regs_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench: two completers (0 and 3 wait states) on one shared bus,
// table-driven transfers plus back-to-back, reset, abort and security cases.
module tb_apb_completer_regfile;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel0, psel3;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PNSE;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_completer_regfile #(.ADDR_W(32), .NUM_REGS(16), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel0), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0)
    );

    apb_completer_regfile #(.ADDR_W(32), .NUM_REGS(16), .WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel3), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3)
    );

    typedef struct {
        string       name;
        bit          d3;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        bit          nse;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_waits;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge PCLK);
        psel0   = 1'b0;
        psel3   = 1'b0;
        PENABLE = 1'b0;
    endtask

    // One full transfer; returns at the negedge where PREADY is seen high
    task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [2:0] prot, input bit nse,
                        output logic [31:0] rd, output logic err, output int waits);
        @(negedge PCLK);
        psel0   = !d3;
        psel3   = d3;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = strb;
        PPROT   = prot;
        PNSE    = nse;
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits   = 0;
        while (!(d3 ? pready3 : pready0) && waits < 20) begin
            @(negedge PCLK);
            waits++;
        end
        rd  = d3 ? prdata3 : prdata0;
        err = d3 ? pslverr3 : pslverr0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          waits;
    bit          saw;

    initial begin
        vecs[0]  = '{"w0_beef",    0, 1, 32'h0,  32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        0, 0};
        vecs[1]  = '{"w4_strb5",   0, 1, 32'h4,  32'hABCDABCD, 4'h5, 3'b000, 0, 32'h0,        0, 0};
        vecs[2]  = '{"w8_strbA",   0, 1, 32'h8,  32'h12345678, 4'hA, 3'b000, 0, 32'h0,        0, 0};
        vecs[3]  = '{"r0",         0, 0, 32'h0,  32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, 0};
        vecs[4]  = '{"r4",         0, 0, 32'h4,  32'h0,        4'hF, 3'b000, 0, 32'h00CD00CD, 0, 0};
        vecs[5]  = '{"r8",         0, 0, 32'h8,  32'h0,        4'h0, 3'b000, 0, 32'h12005600, 0, 0};
        vecs[6]  = '{"ws3_wC",     1, 1, 32'hC,  32'hA5A5A5A5, 4'hF, 3'b000, 0, 32'h0,        0, 3};
        vecs[7]  = '{"ws3_rC",     1, 0, 32'hC,  32'h0,        4'h0, 3'b000, 0, 32'hA5A5A5A5, 0, 3};
        vecs[8]  = '{"w40_range",  0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 32'h0,        1, 0};
        vecs[9]  = '{"r40_range",  0, 0, 32'h40, 32'h0,        4'h0, 3'b000, 0, 32'h0,        1, 0};
        vecs[10] = '{"r2_misal",   0, 0, 32'h2,  32'h0,        4'h0, 3'b000, 0, 32'h0,        1, 0};
        vecs[11] = '{"r0_pnse",    0, 0, 32'h0,  32'h0,        4'h0, 3'b000, 1, 32'h0,        1, 0};
        vecs[12] = '{"r0_again",   0, 0, 32'h0,  32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, 0};
        vecs[13] = '{"w8_nostrb",  0, 1, 32'h8,  32'hFFFFFFFF, 4'h0, 3'b000, 0, 32'h0,        0, 0};
        vecs[14] = '{"r8_kept",    0, 0, 32'h8,  32'h0,        4'h0, 3'b000, 0, 32'h12005600, 0, 0};
        vecs[15] = '{"r1C_nsok",   0, 0, 32'h1C, 32'h0,        4'h0, 3'b010, 1, 32'h0,        0, 0};

        PRESETn = 1'b0;
        psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
        PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0; PPROT = '0; PNSE = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_ready0",  32'(pready0),  32'h0);
        chk("rst_slverr0", 32'(pslverr0), 32'h0);
        chk("rst_rdata0",  prdata0,       32'h0);
        chk("rst_ready3",  32'(pready3),  32'h0);
        PRESETn = 1'b1;

        // Table-driven transfers, one idle cycle between each
        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].d3, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].prot, vecs[i].nse, rd, err, waits);
            chk({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
            chk({vecs[i].name, "_err"},   32'(err),   32'(vecs[i].exp_err));
            chk({vecs[i].name, "_rdata"}, rd,         vecs[i].exp_rd);
            idle();
        end

        // Back-to-back write then read with no idle cycle in between
        xfer(0, 1, 32'h4, 32'h11111111, 4'hF, 3'b000, 0, rd, err, waits);
        chk("b2b_w_waits", 32'(waits), 32'h0);
        xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b000, 0, rd, err, waits);
        chk("b2b_r_waits", 32'(waits), 32'h0);
        chk("b2b_r_err",   32'(err),   32'h0);
        chk("b2b_r_rdata", rd,         32'h11111111);
        idle();

        // Reset pulsed during the access phase of a write
        @(negedge PCLK);
        psel0 = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1;
        PWDATA = 32'h0BADF00D; PSTRB = 4'hF; PPROT = 3'b000; PNSE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        chk("midrst_pre_ready", 32'(pready0), 32'h1);
        PRESETn = 1'b0;
        #1;
        chk("midrst_ready",  32'(pready0),  32'h0);
        chk("midrst_slverr", 32'(pslverr0), 32'h0);
        chk("midrst_rdata",  prdata0,       32'h0);
        @(negedge PCLK);
        psel0 = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 0, rd, err, waits);
        chk("postrst_r0_rdata", rd,         32'h0);
        chk("postrst_r0_err",   32'(err),   32'h0);
        idle();

        // PSELx dropped mid-ACCESS on the wait-state completer
        xfer(1, 1, 32'h8, 32'h13572468, 4'hF, 3'b000, 0, rd, err, waits);
        chk("abort_pre_err", 32'(err), 32'h0);
        idle();
        @(negedge PCLK);
        psel3 = 1'b1; PENABLE = 1'b0; PADDR = 32'h8; PWRITE = 1'b1;
        PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        chk("abort_wait_ready", 32'(pready3), 32'h0);
        @(negedge PCLK);
        psel3 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        // Not a setup phase: an idle completer must ignore this entirely
        psel3 = 1'b1; PENABLE = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            if (pready3) saw = 1'b1;
        end
        chk("abort_idle_noready", 32'(saw), 32'h0);
        idle();
        xfer(1, 0, 32'h8, 32'h0, 4'h0, 3'b000, 0, rd, err, waits);
        chk("abort_r8_rdata", rd,          32'h13572468);
        chk("abort_r8_waits", 32'(waits),  32'h3);
        idle();

`ifdef APB_SECURE_REGION_EN
        xfer(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b010, 0, rd, err, waits);
        chk("sec_ns_w_err", 32'(err), 32'h1);
        idle();
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b000, 0, rd, err, waits);
        chk("sec_r_unchanged", rd,       32'h0);
        chk("sec_r_err",       32'(err), 32'h0);
        idle();
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b010, 0, rd, err, waits);
        chk("sec_ns_r_err", 32'(err), 32'h1);
        idle();
        xfer(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, 0, rd, err, waits);
        chk("sec_s_w_err", 32'(err), 32'h0);
        idle();
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b000, 0, rd, err, waits);
        chk("sec_s_r_rdata", rd,       32'hCAFEF00D);
        chk("sec_s_r_err",   32'(err), 32'h0);
        idle();
`else
        // Without the secure region every in-range index is reachable non-securely
        xfer(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b010, 0, rd, err, waits);
        chk("ns_w20_err", 32'(err), 32'h0);
        idle();
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b010, 1, rd, err, waits);
        chk("ns_r20_rdata", rd,       32'hCAFEF00D);
        chk("ns_r20_err",   32'(err), 32'h0);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
